limp_axi_bridge: RTL and testbench
==================================

LIMP_AXI_BRIDGE -- requirements
Module: limp_axi_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, AXI response wait limit in cycles (used only with LIMP_AXI_TIMEOUT_EN; 1..65535).
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_limp_req  in  limp_pkg::req_s (70)  LIMP request {cmd, addr[33:0], wdata, size}.
REQ-005 o_limp_rsp  out  limp_pkg::rsp_s (34)  LIMP response {status, rdata}.
REQ-006 o_axi_awvalid / i_axi_awready  out/in  1  AXI3 write-address handshake.
REQ-007 o_axi_awaddr, o_axi_araddr  out  32  AXI byte addresses (= addr[31:0]).
REQ-008 o_axi_awsize, o_axi_arsize  out  3  AXI size: BYTE=0, HALFWORD=1, WORD=2.
REQ-009 o_axi_wvalid / i_axi_wready  out/in  1  write-data handshake; o_axi_wdata out 32, o_axi_wstrb out 4.
REQ-010 i_axi_bvalid / o_axi_bready  in/out  1  write response; i_axi_bresp in 2.
REQ-011 o_axi_arvalid / i_axi_arready  out/in  1  read-address handshake; o_axi_arlock out 2.
REQ-012 i_axi_rvalid / o_axi_rready  in/out  1  read data; i_axi_rdata in 32, i_axi_rresp in 2.
REQ-013 Single-beat only; integration ties LEN=0, BURST=INCR, ID=0, WLAST=1.

Function
REQ-014 FSM states IDLE, AR, R, AWW, B, RSP (+DRAIN per REQ-030); one transaction at a time.
REQ-015 IDLE: active req (READ/WRITE/AMO_READ) registered at edge; next state AR (read/AMO), AWW (write), or RSP-illegal; NOP stays IDLE.
REQ-016 Illegal, no AXI traffic: addr[33:32]!=0; size==3; HALFWORD with addr[0]=1; WORD with addr[1:0]!=0; AMO_READ size!=WORD.
REQ-017 AR: arvalid=1 held until arready; then R. R: rready=1; on rvalid capture rdata/rresp, go RSP.
REQ-018 AMO_READ: arlock=2'b01 (exclusive); otherwise arlock=2'b00.
REQ-019 AWW: awvalid and wvalid asserted together, each dropped after its own handshake (either order or same cycle); both done -> B.
REQ-020 B: bready=1; on bvalid capture bresp, go RSP.
REQ-021 Write lanes: BYTE wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0]; HALFWORD {2{wdata[15:0]}}, wstrb=4'b0011<<(2*addr[1]); WORD wstrb=4'b1111.
REQ-022 Read lanes: rdata shifted right by 8*addr[1:0]; unused upper bits zero.
REQ-023 RSP: exactly one cycle; status READY_READ (read/AMO ok), READY_WRITE (write ok), READY_ILLEGAL (REQ-016 or resp[1]=1); OKAY and EXOKAY are ok; then IDLE.
REQ-024 All other cycles status=NOT_READY, rdata=0; rdata=0 unless READY_READ.
REQ-025 Requester holds req stable until RSP; bridge ignores req outside IDLE; new req accepted in IDLE the cycle after RSP.
REQ-026 Minimum latency: read 4 cycles (IDLE, AR, R, RSP), illegal 2 cycles (IDLE, RSP).

Reset
REQ-027 i_rst -> IDLE next edge; all valid/ready outputs 0, arlock 0, status NOT_READY, rdata 0, addr/data/strb 0.
REQ-028 Reset mid-transaction abandons it without response; AXI slave is reset by the same i_rst.

Configuration
REQ-029 Macro LIMP_AXI_TIMEOUT_EN; absent: no counter, no DRAIN, R/B wait indefinitely.
REQ-030 Present: counter clears entering R/B; reaching TIMEOUT_CYCLES without rvalid/bvalid -> RSP READY_ILLEGAL, then DRAIN (rready/bready=1) until late rvalid/bvalid consumed, then IDLE; AR/AWW never time out.

Verification
REQ-031 READ WORD addr 0x0_8000_0004, arready and rvalid immediate, rdata 0xDEADBEEF -> araddr 0x80000004, arsize 2, READY_READ rdata 0xDEADBEEF on cycle 4.
REQ-032 WRITE BYTE addr 0x0_0000_0103 wdata 0xA5, wready 2 cycles before awready -> wdata 0xA5A5A5A5, wstrb 4'b1000, one READY_WRITE after bvalid.
REQ-033 READ HALFWORD addr 0x1_0000_0002 -> READY_ILLEGAL next cycle, no arvalid.
REQ-034 AMO_READ WORD, rresp=2'b01 -> arlock 2'b01, READY_READ; rresp=2'b10 -> READY_ILLEGAL.
REQ-035 With macro, TIMEOUT_CYCLES=8, rvalid at cycle 20 -> READY_ILLEGAL after 8 R cycles, DRAIN absorbs beat, next request serviced normally; i_rst in R -> all outputs reset values.

Source files
------------

// File: rtl/limp_axi_bridge.sv
// LIMP-to-AXI3 single-beat bridge: one LIMP request at a time becomes one AXI read or write.
// Optional response timeout with drain state is enabled by defining LIMP_AXI_TIMEOUT_EN.
package limp_pkg;
  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_READ     = 2'd1;
  localparam logic [1:0] CMD_WRITE    = 2'd2;
  localparam logic [1:0] CMD_AMO_READ = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_NOT_READY     = 2'd0;
  localparam logic [1:0] ST_READY_READ    = 2'd1;
  localparam logic [1:0] ST_READY_WRITE   = 2'd2;
  localparam logic [1:0] ST_READY_ILLEGAL = 2'd3;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [33:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } req_s;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] rdata;
  } rsp_s;
endpackage

module limp_axi_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  limp_pkg::req_s  i_limp_req,
  output limp_pkg::rsp_s  o_limp_rsp,
  output logic            o_axi_awvalid,
  input  logic            i_axi_awready,
  output logic [31:0]     o_axi_awaddr,
  output logic [2:0]      o_axi_awsize,
  output logic            o_axi_wvalid,
  input  logic            i_axi_wready,
  output logic [31:0]     o_axi_wdata,
  output logic [3:0]      o_axi_wstrb,
  input  logic            i_axi_bvalid,
  output logic            o_axi_bready,
  input  logic [1:0]      i_axi_bresp,
  output logic            o_axi_arvalid,
  input  logic            i_axi_arready,
  output logic [31:0]     o_axi_araddr,
  output logic [2:0]      o_axi_arsize,
  output logic [1:0]      o_axi_arlock,
  input  logic            i_axi_rvalid,
  output logic            o_axi_rready,
  input  logic [31:0]     i_axi_rdata,
  input  logic [1:0]      i_axi_rresp
);
  import limp_pkg::*;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_R     = 3'd2;
  localparam logic [2:0] S_AWW   = 3'd3;
  localparam logic [2:0] S_B     = 3'd4;
  localparam logic [2:0] S_RSP   = 3'd5;
`ifdef LIMP_AXI_TIMEOUT_EN
  localparam logic [2:0] S_DRAIN = 3'd6;
`endif

  function automatic logic is_illegal(input req_s r);
    return (r.addr[33:32] != 2'b00) || (r.size == 2'b11) ||
           ((r.size == SIZE_HALF) && r.addr[0]) ||
           ((r.size == SIZE_WORD) && (r.addr[1:0] != 2'b00)) ||
           ((r.cmd == CMD_AMO_READ) && (r.size != SIZE_WORD));
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return {4{d[7:0]}};
      SIZE_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

  function automatic logic [3:0] lane_wstrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << {off[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input logic [31:0] d, input logic [1:0] size,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (size)
      SIZE_BYTE: return {24'h000000, sh[7:0]};
      SIZE_HALF: return {16'h0000, sh[15:0]};
      default:   return sh;
    endcase
  endfunction

  // SLVERR and DECERR are the failing responses; OKAY and EXOKAY both succeed.
  function automatic logic resp_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  logic [2:0]  state_r;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  rsp_s        rsp_r;
  logic        awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic [31:0] awaddr_r, araddr_r, wdata_r;
  logic [2:0]  awsize_r, arsize_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  arlock_r;
`ifdef LIMP_AXI_TIMEOUT_EN
  logic [15:0] tmr_r;
  logic        drain_rd_r, drain_wr_r;
`endif

  // Transaction FSM; every AXI and LIMP output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= S_IDLE;
      off_r     <= 2'b00;
      size_r    <= 2'b00;
      rsp_r     <= '0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awaddr_r  <= 32'h0;
      araddr_r  <= 32'h0;
      wdata_r   <= 32'h0;
      awsize_r  <= 3'd0;
      arsize_r  <= 3'd0;
      wstrb_r   <= 4'h0;
      arlock_r  <= 2'b00;
`ifdef LIMP_AXI_TIMEOUT_EN
      tmr_r      <= 16'h0;
      drain_rd_r <= 1'b0;
      drain_wr_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_limp_req.cmd != CMD_NOP) begin
            off_r  <= i_limp_req.addr[1:0];
            size_r <= i_limp_req.size;
            if (is_illegal(i_limp_req)) begin
              rsp_r.status <= ST_READY_ILLEGAL;
              state_r      <= S_RSP;
            end else if (i_limp_req.cmd == CMD_WRITE) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              awaddr_r  <= i_limp_req.addr[31:0];
              awsize_r  <= {1'b0, i_limp_req.size};
              wdata_r   <= lane_wdata(i_limp_req.wdata, i_limp_req.size);
              wstrb_r   <= lane_wstrb(i_limp_req.size, i_limp_req.addr[1:0]);
              state_r   <= S_AWW;
            end else begin
              arvalid_r <= 1'b1;
              araddr_r  <= i_limp_req.addr[31:0];
              arsize_r  <= {1'b0, i_limp_req.size};
              arlock_r  <= (i_limp_req.cmd == CMD_AMO_READ) ? 2'b01 : 2'b00;
              state_r   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (i_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= S_R;
`ifdef LIMP_AXI_TIMEOUT_EN
            tmr_r     <= 16'h0;
`endif
          end
        end
        S_R: begin
          if (i_axi_rvalid) begin
            rready_r <= 1'b0;
            state_r  <= S_RSP;
            if (resp_err(i_axi_rresp)) begin
              rsp_r.status <= ST_READY_ILLEGAL;
            end else begin
              rsp_r.status <= ST_READY_READ;
              rsp_r.rdata  <= lane_rdata(i_axi_rdata, size_r, off_r);
            end
          end
`ifdef LIMP_AXI_TIMEOUT_EN
          else if (tmr_r == 16'(TIMEOUT_CYCLES - 1)) begin
            rready_r     <= 1'b0;
            drain_rd_r   <= 1'b1;
            rsp_r.status <= ST_READY_ILLEGAL;
            state_r      <= S_RSP;
          end else begin
            tmr_r <= tmr_r + 16'd1;
          end
`endif
        end
        S_AWW: begin
          // Address and data channels complete independently, in either order.
          if (i_axi_awready) awvalid_r <= 1'b0;
          if (i_axi_wready)  wvalid_r  <= 1'b0;
          if ((!awvalid_r || i_axi_awready) && (!wvalid_r || i_axi_wready)) begin
            bready_r <= 1'b1;
            state_r  <= S_B;
`ifdef LIMP_AXI_TIMEOUT_EN
            tmr_r    <= 16'h0;
`endif
          end
        end
        S_B: begin
          if (i_axi_bvalid) begin
            bready_r     <= 1'b0;
            rsp_r.status <= resp_err(i_axi_bresp) ? ST_READY_ILLEGAL : ST_READY_WRITE;
            state_r      <= S_RSP;
          end
`ifdef LIMP_AXI_TIMEOUT_EN
          else if (tmr_r == 16'(TIMEOUT_CYCLES - 1)) begin
            bready_r     <= 1'b0;
            drain_wr_r   <= 1'b1;
            rsp_r.status <= ST_READY_ILLEGAL;
            state_r      <= S_RSP;
          end else begin
            tmr_r <= tmr_r + 16'd1;
          end
`endif
        end
        S_RSP: begin
          rsp_r   <= '0;
          state_r <= S_IDLE;
`ifdef LIMP_AXI_TIMEOUT_EN
          // A timed-out beat may still arrive; swallow it before taking new work.
          if (drain_rd_r || drain_wr_r) begin
            rready_r <= drain_rd_r;
            bready_r <= drain_wr_r;
            state_r  <= S_DRAIN;
          end
`endif
        end
`ifdef LIMP_AXI_TIMEOUT_EN
        S_DRAIN: begin
          if ((rready_r && i_axi_rvalid) || (bready_r && i_axi_bvalid)) begin
            rready_r   <= 1'b0;
            bready_r   <= 1'b0;
            drain_rd_r <= 1'b0;
            drain_wr_r <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
`endif
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign o_limp_rsp    = rsp_r;
  assign o_axi_awvalid = awvalid_r;
  assign o_axi_awaddr  = awaddr_r;
  assign o_axi_awsize  = awsize_r;
  assign o_axi_wvalid  = wvalid_r;
  assign o_axi_wdata   = wdata_r;
  assign o_axi_wstrb   = wstrb_r;
  assign o_axi_bready  = bready_r;
  assign o_axi_arvalid = arvalid_r;
  assign o_axi_araddr  = araddr_r;
  assign o_axi_arsize  = arsize_r;
  assign o_axi_arlock  = arlock_r;
  assign o_axi_rready  = rready_r;
endmodule

// File: tb/tb_limp_axi_bridge.sv
// Directed, table-driven bench for limp_axi_bridge with a reactive single-beat AXI slave.
module tb_limp_axi_bridge;
  import limp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  req_s        i_limp_req;
  rsp_s        o_limp_rsp;
  logic        o_axi_awvalid, i_axi_awready;
  logic [31:0] o_axi_awaddr;
  logic [2:0]  o_axi_awsize;
  logic        o_axi_wvalid, i_axi_wready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        i_axi_bvalid, o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic        o_axi_arvalid, i_axi_arready;
  logic [31:0] o_axi_araddr;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arlock;
  logic        i_axi_rvalid, o_axi_rready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  limp_axi_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_limp_req(i_limp_req), .o_limp_rsp(o_limp_rsp),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awsize(o_axi_awsize),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arsize(o_axi_arsize), .o_axi_arlock(o_axi_arlock),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [33:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          a_dly;      // arready / awready delay
    int          w_dly;      // wready delay
    int          r_dly;      // rvalid / bvalid delay
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          exp_axi;
    logic [1:0]  exp_lock;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [1:0] cmd, input logic [33:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input int a, input int w, input int r,
                              input logic [31:0] rdata, input logic [1:0] resp,
                              input bit axi, input logic [1:0] lock,
                              input logic [31:0] ewd, input logic [3:0] ews,
                              input logic [1:0] st, input logic [31:0] erd, input int lat);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.size = size;
    v.a_dly = a; v.w_dly = w; v.r_dly = r; v.rdata = rdata; v.resp = resp;
    v.exp_axi = axi; v.exp_lock = lock; v.exp_wdata = ewd; v.exp_wstrb = ews;
    v.exp_status = st; v.exp_rdata = erd; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_bvalid = 1'b0; i_axi_bresp = 2'b00;
    i_axi_arready = 1'b0; i_axi_rvalid = 1'b0; i_axi_rdata = 32'h0; i_axi_rresp = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {27'h0, o_axi_arvalid, o_axi_awvalid, o_axi_wvalid,
                             o_axi_bready, o_axi_rready}, 32'h0);
    check({tag, "_arlock"}, {30'h0, o_axi_arlock}, 32'h0);
    check({tag, "_status"}, {30'h0, o_limp_rsp.status}, {30'h0, ST_NOT_READY});
    check({tag, "_rdata"}, o_limp_rsp.rdata, 32'h0);
    check({tag, "_addr"}, o_axi_awaddr | o_axi_araddr, 32'h0);
    check({tag, "_data"}, o_axi_wdata | {28'h0, o_axi_wstrb} | {26'h0, o_axi_awsize, o_axi_arsize},
          32'h0);
  endtask

  // Starts and ends at a falling edge with the bridge idle.
  task automatic run_vec(input int idx, input vec_t v);
    int  cyc = 1;
    int  ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    bit  ar_seen = 0, aw_seen = 0, w_seen = 0, done = 0;
    string p;
    p = $sformatf("v%0d", idx);
    i_limp_req = '{cmd: v.cmd, addr: v.addr, wdata: v.wdata, size: v.size};
    slave_idle();
    while (!done && cyc < 60) begin
      @(posedge i_clk);
      @(negedge i_clk);
      cyc++;
      if (o_axi_arvalid) begin
        if (!ar_seen) begin
          check({p, "_araddr"}, o_axi_araddr, v.addr[31:0]);
          check({p, "_arsize"}, {29'h0, o_axi_arsize}, {30'h0, v.size});
          check({p, "_arlock"}, {30'h0, o_axi_arlock}, {30'h0, v.exp_lock});
        end
        ar_seen = 1;
        ar_cnt++;
      end
      if (o_axi_awvalid) begin
        if (!aw_seen) begin
          check({p, "_awaddr"}, o_axi_awaddr, v.addr[31:0]);
          check({p, "_awsize"}, {29'h0, o_axi_awsize}, {30'h0, v.size});
        end
        aw_seen = 1;
        aw_cnt++;
      end
      if (o_axi_wvalid) begin
        if (!w_seen) begin
          check({p, "_wdata"}, o_axi_wdata, v.exp_wdata);
          check({p, "_wstrb"}, {28'h0, o_axi_wstrb}, {28'h0, v.exp_wstrb});
        end
        w_seen = 1;
        w_cnt++;
      end
      if (o_axi_rready) r_cnt++;
      if (o_axi_bready) b_cnt++;
      i_axi_arready = o_axi_arvalid && (ar_cnt > v.a_dly);
      i_axi_awready = o_axi_awvalid && (aw_cnt > v.a_dly);
      i_axi_wready  = o_axi_wvalid && (w_cnt > v.w_dly);
      i_axi_rvalid  = o_axi_rready && (r_cnt > v.r_dly);
      i_axi_rdata   = i_axi_rvalid ? v.rdata : 32'h5A5A0F0F;
      i_axi_rresp   = i_axi_rvalid ? v.resp : 2'b00;
      i_axi_bvalid  = o_axi_bready && (b_cnt > v.r_dly);
      i_axi_bresp   = i_axi_bvalid ? v.resp : 2'b00;
      if (o_limp_rsp.status != ST_NOT_READY) begin
        done = 1;
        check({p, "_status"}, {30'h0, o_limp_rsp.status}, {30'h0, v.exp_status});
        check({p, "_rdata"}, o_limp_rsp.rdata, v.exp_rdata);
        check({p, "_latency"}, cyc, v.exp_lat);
      end
    end
    if (!done) check({p, "_rsp_timeout"}, 32'd0, 32'd1);
    check({p, "_axi_traffic"}, {31'h0, ar_seen | aw_seen | w_seen}, {31'h0, v.exp_axi});
    i_limp_req = '0;
    slave_idle();
    @(posedge i_clk);
    @(negedge i_clk);
    check({p, "_rsp_one_cycle"}, {30'h0, o_limp_rsp.status}, {30'h0, ST_NOT_READY});
  endtask

  initial begin
    vecs[0]  = mk(CMD_READ, 34'h0_8000_0004, 32'h0, SIZE_WORD, 0, 0, 0, 32'hDEADBEEF, 2'b00,
                  1, 2'b00, 32'h0, 4'h0, ST_READY_READ, 32'hDEADBEEF, 4);
    vecs[1]  = mk(CMD_WRITE, 34'h0_0000_0103, 32'h000000A5, SIZE_BYTE, 2, 0, 1, 32'h0, 2'b00,
                  1, 2'b00, 32'hA5A5A5A5, 4'b1000, ST_READY_WRITE, 32'h0, 7);
    vecs[2]  = mk(CMD_READ, 34'h1_0000_0002, 32'h0, SIZE_HALF, 0, 0, 0, 32'h0, 2'b00,
                  0, 2'b00, 32'h0, 4'h0, ST_READY_ILLEGAL, 32'h0, 2);
    vecs[3]  = mk(CMD_AMO_READ, 34'h0_0000_0100, 32'h0, SIZE_WORD, 0, 0, 0, 32'h11223344, 2'b01,
                  1, 2'b01, 32'h0, 4'h0, ST_READY_READ, 32'h11223344, 4);
    vecs[4]  = mk(CMD_AMO_READ, 34'h0_0000_0200, 32'h0, SIZE_WORD, 0, 0, 0, 32'h99887766, 2'b10,
                  1, 2'b01, 32'h0, 4'h0, ST_READY_ILLEGAL, 32'h0, 4);
    vecs[5]  = mk(CMD_READ, 34'h0_0000_0002, 32'h0, SIZE_BYTE, 1, 0, 2, 32'hAABBCCDD, 2'b00,
                  1, 2'b00, 32'h0, 4'h0, ST_READY_READ, 32'h000000BB, 7);
    vecs[6]  = mk(CMD_READ, 34'h0_0000_0006, 32'h0, SIZE_HALF, 0, 0, 0, 32'hCAFE1234, 2'b00,
                  1, 2'b00, 32'h0, 4'h0, ST_READY_READ, 32'h0000CAFE, 4);
    vecs[7]  = mk(CMD_WRITE, 34'h0_0000_0012, 32'h0000BEEF, SIZE_HALF, 0, 1, 0, 32'h0, 2'b00,
                  1, 2'b00, 32'hBEEFBEEF, 4'b1100, ST_READY_WRITE, 32'h0, 5);
    vecs[8]  = mk(CMD_WRITE, 34'h0_0000_0020, 32'h01234567, SIZE_WORD, 0, 0, 0, 32'h0, 2'b11,
                  1, 2'b00, 32'h01234567, 4'b1111, ST_READY_ILLEGAL, 32'h0, 4);
    vecs[9]  = mk(CMD_WRITE, 34'h0_0000_0021, 32'h01234567, SIZE_WORD, 0, 0, 0, 32'h0, 2'b00,
                  0, 2'b00, 32'h0, 4'h0, ST_READY_ILLEGAL, 32'h0, 2);
    vecs[10] = mk(CMD_READ, 34'h0_0000_0000, 32'h0, 2'b11, 0, 0, 0, 32'h0, 2'b00,
                  0, 2'b00, 32'h0, 4'h0, ST_READY_ILLEGAL, 32'h0, 2);
    vecs[11] = mk(CMD_AMO_READ, 34'h0_0000_0000, 32'h0, SIZE_HALF, 0, 0, 0, 32'h0, 2'b00,
                  0, 2'b00, 32'h0, 4'h0, ST_READY_ILLEGAL, 32'h0, 2);
    vecs[12] = mk(CMD_WRITE, 34'h0_0000_0001, 32'h0000003C, SIZE_BYTE, 0, 0, 0, 32'h0, 2'b01,
                  1, 2'b00, 32'h3C3C3C3C, 4'b0010, ST_READY_WRITE, 32'h0, 4);
    vecs[13] = mk(CMD_READ, 34'h0_0000_0008, 32'h0, SIZE_WORD, 2, 0, 3, 32'h13579BDF, 2'b01,
                  1, 2'b00, 32'h0, 4'h0, ST_READY_READ, 32'h13579BDF, 9);

    i_rst = 1'b1;
    i_limp_req = '0;
    slave_idle();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;

    // NOP keeps the bridge idle and silent.
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check($sformatf("nop%0d_quiet", i),
            {28'h0, o_axi_arvalid, o_axi_awvalid, o_limp_rsp.status}, 32'h0);
    end

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

`ifndef LIMP_AXI_TIMEOUT_EN
    // Without the timeout the bridge waits as long as the slave takes.
    run_vec(14, mk(CMD_READ, 34'h0_0000_0044, 32'h0, SIZE_WORD, 0, 0, 20, 32'h0F1E2D3C, 2'b00,
                   1, 2'b00, 32'h0, 4'h0, ST_READY_READ, 32'h0F1E2D3C, 24));
`else
    begin
      int cyc = 1, n_rsp = 0, rsp_cyc = 0;
      bit consumed = 0;
      logic [1:0]  rsp_st = 2'b00;
      logic [31:0] rsp_rd = 32'hFFFFFFFF;
      i_limp_req = '{cmd: CMD_READ, addr: 34'h0_0000_0080, wdata: 32'h0, size: SIZE_WORD};
      slave_idle();
      while (cyc < 26) begin
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        if (i_axi_rvalid) consumed = 1;
        i_axi_arready = o_axi_arvalid;
        if (o_limp_rsp.status != ST_NOT_READY) begin
          n_rsp++;
          rsp_cyc = cyc;
          rsp_st = o_limp_rsp.status;
          rsp_rd = o_limp_rsp.rdata;
          i_limp_req = '0;
        end
        if (cyc == 15) check("tmo_drain_rready", {31'h0, o_axi_rready}, 32'd1);
        i_axi_rvalid = o_axi_rready && (cyc >= 20) && !consumed;
        i_axi_rdata  = i_axi_rvalid ? 32'h0BADF00D : 32'h0;
      end
      check("tmo_rsp_count", n_rsp, 32'd1);
      check("tmo_rsp_cycle", rsp_cyc, 32'd11);
      check("tmo_status", {30'h0, rsp_st}, {30'h0, ST_READY_ILLEGAL});
      check("tmo_rdata", rsp_rd, 32'h0);
      check("tmo_beat_drained", {31'h0, consumed}, 32'd1);
      check("tmo_idle_rready", {31'h0, o_axi_rready}, 32'd0);
      slave_idle();
      run_vec(20, vecs[0]);
    end
`endif

    // Reset while waiting in R abandons the read with no response.
    i_limp_req = '{cmd: CMD_READ, addr: 34'h0_0000_0040, wdata: 32'h0, size: SIZE_WORD};
    slave_idle();
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_axi_arready = o_axi_arvalid;
    end
    check("mid_rready", {31'h0, o_axi_rready}, 32'd1);
    i_rst = 1'b1;
    slave_idle();
    @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("mid_reset");
    i_rst = 1'b0;
    i_limp_req = '0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("mid_no_rsp", {30'h0, o_limp_rsp.status}, {30'h0, ST_NOT_READY});
    run_vec(30, vecs[13]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
